// File: rtl/frame_write_sequencer.sv
// Frame-latch write sequencer: each accepted (frame, word) request drives FrameData through setup,
// one-hot FrameStrobe and hold phases. Optional feature macro: FRAME_SEQ_PARITY_EN (even parity on s_data).
module frame_write_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 2,
  parameter int HoldCycles      = 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [$clog2(MaxFramesPerCol)-1:0] s_frame,
  input  logic [FrameBitsPerRow-1:0]         s_data,
  input  logic                               s_parity,
  input  logic                               err_clr,
  output logic [FrameBitsPerRow-1:0]         FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               err_index,
  output logic                               err_parity,
  output logic [15:0]                        frames_written,
  output logic [1:0]                         dbg_state
);
  localparam int FW = $clog2(MaxFramesPerCol);
  localparam int CW = 16;
  localparam logic [CW-1:0] SetupLd  = CW'(SetupCycles - 1);
  localparam logic [CW-1:0] StrobeLd = CW'(StrobeCycles - 1);
  localparam logic [CW-1:0] HoldLd   = CW'(HoldCycles - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [FW-1:0]                frame_q, frame_d;
  logic [FrameBitsPerRow-1:0]   word_q, word_d;
  logic                         s_ready_q, s_ready_d;
  logic [FrameBitsPerRow-1:0]   data_q, data_d;
  logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         err_index_q, err_index_d;
  logic [15:0]                  count_q, count_d;
  logic                         accept, idx_bad, par_bad;

  // Handshake: a request transfers on a rising edge where s_valid && s_ready are both high.
  // s_ready is high only in IDLE, so nothing is queued; every transferred request is either
  // written (legal) or dropped with a sticky error flag.
  assign accept  = s_valid && s_ready_q;
  assign idx_bad = int'(s_frame) >= MaxFramesPerCol;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    word_d  = word_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !idx_bad && !par_bad) begin
          state_d = SETUP;
          cnt_d   = SetupLd;
          frame_d = s_frame;
          word_d  = s_data;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they line up with state_q after the edge.
    s_ready_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    data_d    = (state_d != IDLE) ? word_d : '0;
    strobe_d  = (state_d == STROBE) ? (MaxFramesPerCol'(1) << frame_d) : '0;
    done_d    = (state_d == HOLD) && (cnt_d == '0);
    if (done_d) begin
      count_d = count_q + 16'd1;
    end
    err_index_d = (err_clr ? 1'b0 : err_index_q) | (accept & idx_bad);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      word_q      <= '0;
      s_ready_q   <= 1'b0;
      data_q      <= '0;
      strobe_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_index_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      word_q      <= word_d;
      s_ready_q   <= s_ready_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_index_q <= err_index_d;
      count_q     <= count_d;
    end
  end

`ifdef FRAME_SEQ_PARITY_EN
  logic err_parity_q, err_parity_d;

  assign par_bad      = (s_parity != ^s_data);
  assign err_parity_d = (err_clr ? 1'b0 : err_parity_q) | (accept & par_bad);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_parity_q <= 1'b0;
    end else begin
      err_parity_q <= err_parity_d;
    end
  end

  assign err_parity = err_parity_q;
`else
  logic unused_parity;

  assign par_bad       = 1'b0;
  assign unused_parity = s_parity;
  assign err_parity    = 1'b0;
`endif

  assign s_ready        = s_ready_q;
  assign FrameData      = data_q;
  assign FrameStrobe    = strobe_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign err_index      = err_index_q;
  assign frames_written = count_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_frame_write_sequencer.sv
// Bench for frame_write_sequencer: randomized requests, a transaction-level reference model
// and a negedge monitor that compares every cycle; plus a directed run of a 3/1/2 phase instance.
`timescale 1ns/1ps
module tb_frame_write_sequencer;
  localparam int NF = 20;
  localparam int W  = 32;
  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int T  = S + P + H;
  localparam int FW = $clog2(NF);
  localparam int TW = 32 + FW + W;
`ifdef FRAME_SEQ_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FW-1:0] s_frame = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_parity = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          busy, frame_done, err_index, err_parity;
  logic [15:0]   frames_written;
  logic [1:0]    dbg_state;

  frame_write_sequencer #(.MaxFramesPerCol(NF), .FrameBitsPerRow(W),
    .SetupCycles(S), .StrobeCycles(P), .HoldCycles(H)) dut (
    .CLK(CLK), .RESET(RESET), .s_valid(s_valid), .s_ready(s_ready), .s_frame(s_frame),
    .s_data(s_data), .s_parity(s_parity), .err_clr(err_clr), .FrameData(FrameData),
    .FrameStrobe(FrameStrobe), .busy(busy), .frame_done(frame_done), .err_index(err_index),
    .err_parity(err_parity), .frames_written(frames_written), .dbg_state(dbg_state));

  // Second instance with setup=3, strobe=1, hold=2.
  logic          rst2 = 1'b1;
  logic          v2 = 1'b0;
  logic          rdy2;
  logic [FW-1:0] f2 = '0;
  logic [W-1:0]  d2 = '0;
  logic          p2 = 1'b0;
  logic [W-1:0]  data2;
  logic [NF-1:0] strobe2;
  logic          busy2, done2, eidx2, epar2;
  logic [15:0]   cnt2;
  logic [1:0]    dbg2;

  frame_write_sequencer #(.MaxFramesPerCol(NF), .FrameBitsPerRow(W),
    .SetupCycles(3), .StrobeCycles(1), .HoldCycles(2)) dut2 (
    .CLK(CLK), .RESET(rst2), .s_valid(v2), .s_ready(rdy2), .s_frame(f2),
    .s_data(d2), .s_parity(p2), .err_clr(1'b0), .FrameData(data2),
    .FrameStrobe(strobe2), .busy(busy2), .frame_done(done2), .err_index(eidx2),
    .err_parity(epar2), .frames_written(cnt2), .dbg_state(dbg2));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [TW-1:0] exp_q[$];   // {accept cycle, frame, word} of every write expected to complete
  int idx_set_q[$];
  int par_set_q[$];
  int clr_q[$];
  int exp_cnt = 0;
  logic e_err_idx = 1'b0;
  logic e_err_par = 1'b0;
  logic rst_prev = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [FW-1:0] fr, input logic [W-1:0] d, input logic par,
                      input logic clr);
    int waited;
    bit bad_idx, bad_par;
    waited = 0;
    s_valid = 1'b1; s_frame = fr; s_data = d; s_parity = par;
    while (!s_ready) begin
      step(1);
      waited++;
      if (waited > 40) begin
        checks++; errors++;
        $display("FAIL accept_timeout cyc=%0d actual=no_ready required=ready", cyc);
        s_valid = 1'b0;
        return;
      end
    end
    bad_idx = (int'(fr) >= NF);
    bad_par = PAR_EN && (par != ^d);
    if (clr) begin
      err_clr = 1'b1;
      clr_q.push_back(cyc + 1);
    end
    if (bad_idx) idx_set_q.push_back(cyc + 1);
    if (bad_par) par_set_q.push_back(cyc + 1);
    if (!bad_idx && !bad_par) exp_q.push_back({32'(cyc), fr, d});
    step(1);
    s_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    clr_q.push_back(cyc + 1);
    step(1);
    err_clr = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic check_cycle();
    logic [W-1:0]  e_data;
    logic [NF-1:0] e_strobe;
    logic          e_done, e_busy, e_ready;
    logic [TW-1:0] t;
    int            rel, c, fi;
    bit            pop;
    pop = 0;
    if (rst_prev) begin
      exp_q.delete(); idx_set_q.delete(); par_set_q.delete(); clr_q.delete();
      exp_cnt = 0; e_err_idx = 1'b0; e_err_par = 1'b0;
      chk("rst_ready", 64'(s_ready), 64'd0);
      chk("rst_data", 64'(FrameData), 64'd0);
      chk("rst_strobe", 64'(FrameStrobe), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(frame_done), 64'd0);
      chk("rst_err_index", 64'(err_index), 64'd0);
      chk("rst_err_parity", 64'(err_parity), 64'd0);
      chk("rst_count", 64'(frames_written), 64'd0);
      return;
    end
    while (clr_q.size() > 0 && clr_q[0] <= cyc) begin
      void'(clr_q.pop_front()); e_err_idx = 1'b0; e_err_par = 1'b0;
    end
    while (idx_set_q.size() > 0 && idx_set_q[0] <= cyc) begin
      void'(idx_set_q.pop_front()); e_err_idx = 1'b1;
    end
    while (par_set_q.size() > 0 && par_set_q[0] <= cyc) begin
      void'(par_set_q.pop_front()); e_err_par = 1'b1;
    end
    e_data = '0; e_strobe = '0; e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    if (exp_q.size() > 0) begin
      t = exp_q[0];
      c = int'(t[TW-1 -: 32]);
      fi = int'(t[W +: FW]);
      rel = cyc - c;
      if (rel >= 1) begin
        e_busy = 1'b1; e_ready = 1'b0; e_data = t[W-1:0];
        if (rel >= 1 + S && rel <= S + P) e_strobe[fi] = 1'b1;
        if (rel == T) begin
          e_done = 1'b1;
          pop = 1;
        end
      end
    end
    chk("ready", 64'(s_ready), 64'(e_ready));
    chk("frame_data", 64'(FrameData), 64'(e_data));
    chk("frame_strobe", 64'(FrameStrobe), 64'(e_strobe));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("frame_done", 64'(frame_done), 64'(e_done));
    chk("err_index", 64'(err_index), 64'(e_err_idx));
    chk("err_parity", 64'(err_parity), 64'(e_err_par));
    if (!e_busy) chk("frames_written", 64'(frames_written), 64'(exp_cnt));
    if (pop) begin
      void'(exp_q.pop_front());
      exp_cnt = (exp_cnt + 1) % 65536;
    end
  endtask

  always @(negedge CLK) begin
    check_cycle();
    rst_prev = RESET;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] fr;
    logic [W-1:0]  d;
    logic          par;
    int            c2, rel;
    step(3);
    RESET = 1'b0;
    step(2);

    send(FW'(5), 32'hA5A5_0001, ^32'hA5A5_0001, 1'b0);
    step(6);

    d = $urandom;
    send(FW'(0), d, ^d, 1'b0);
    d = $urandom;
    send(FW'(19), d, ^d, 1'b0);
    step(6);

    send(FW'(20), 32'h1234_5678, ^32'h1234_5678, 1'b0);
    step(3);
    pulse_clr();
    step(2);

    send(FW'(1), 32'h1, 1'b0, 1'b0);
    step(3);
    send(FW'(1), 32'h1, 1'b1, 1'b0);
    step(6);

    for (int i = 0; i < 150; i++) begin
      fr = FW'($urandom_range(0, 23));
      d = $urandom;
      par = ^d;
      if ($urandom_range(0, 7) == 0) par = ~par;
      send(fr, d, par, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) pulse_clr();
        step($urandom_range(1, 3));
      end
    end
    step(6);

    d = $urandom;
    send(FW'(5), d, ^d, 1'b0);
    step(S);
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(3);
    d = $urandom;
    send(FW'(11), d, ^d, 1'b0);
    step(6);

    // 3/1/2 instance: strobe only at cycle 4, frame_done at cycle 6, ready again at cycle 7.
    rst2 = 1'b0;
    step(2);
    v2 = 1'b1; f2 = FW'(7); d2 = $urandom; p2 = ^d2;
    c2 = -1;
    for (int k = 0; k < 10 && c2 < 0; k++) begin
      if (rdy2) c2 = cyc;
      else step(1);
    end
    if (c2 < 0) begin
      checks++; errors++;
      $display("FAIL alt_accept_timeout cyc=%0d actual=no_ready required=ready", cyc);
    end else begin
      step(1);
      v2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        rel = cyc - c2;
        chk("alt_strobe", 64'(strobe2), (rel == 4) ? 64'(1 << 7) : 64'd0);
        chk("alt_done", 64'(done2), 64'(rel == 6));
        chk("alt_data", 64'(data2), (rel >= 1 && rel <= 6) ? 64'(d2) : 64'd0);
        chk("alt_ready", 64'(rdy2), 64'(rel >= 7));
        if (rel >= 7) chk("alt_count", 64'(cnt2), 64'd1);
      end
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
